// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_pkg;

    typedef struct packed {
        logic brk;
        logic stop;
        logic parity;
    } rx_err_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RECOVER = 2'd3
    } rx_state_t;

    localparam int unsigned RX_IDLE_TICKS = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with extra-MSB pointers for full/empty detection.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer: baud tick generator, receiver arming FSM, RX FIFO and sticky status.
// Optional macro UART_RX_CTRL_ERR_DROP_EN: discard characters with parity/stop errors.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_enable,
    input  logic [DIV_WIDTH-1:0] cfg_baud_div,
    output logic                 sample_tick,
    output logic                 rx_start_n,
    input  logic                 serial_data_in,
    input  logic                 rx_done,
    input  logic [DATA_SIZE-1:0] data_out,
    input  logic                 parity_error,
    input  logic                 stop_error,
    input  logic                 break_error,
    input  logic                 overflow_error,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic [2:0]           rx_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 sts_overrun,
    output logic                 sts_break,
    input  logic                 sts_clr,
    output logic                 busy
);

    localparam int unsigned IDLE_CNT_W = $clog2(RX_IDLE_TICKS);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(RX_IDLE_TICKS - 1);

    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  run_q;
    rx_state_t             state_q, state_d;
    logic                  rx_done_q;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  sts_overrun_q, sts_overrun_d;
    logic                  sts_break_q, sts_break_d;
    logic                  set_ovr, set_brk;
    logic                  push, pop, char_keep;
    logic                  fifo_full, fifo_empty;
    rx_err_t               cap_err;
    logic [DATA_SIZE+2:0]  fifo_rdata;

    // First reload after enable uses div-1 so the first tick lands div cycles after enable.
    always_comb begin
        cnt_d = cnt_q;
        if (!cfg_enable)       cnt_d = '0;
        else if (!run_q)       cnt_d = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_WIDTH'(1);
        else if (cnt_q == '0)  cnt_d = cfg_baud_div;
        else                   cnt_d = cnt_q - DIV_WIDTH'(1);
    end

    assign sample_tick = cfg_enable & run_q & (cnt_q == '0);

    assign cap_err.brk    = break_error;
    assign cap_err.stop   = stop_error;
    assign cap_err.parity = parity_error;

`ifdef UART_RX_CTRL_ERR_DROP_EN
    assign char_keep = break_error | ~(parity_error | stop_error);
`else
    assign char_keep = 1'b1;
`endif

    assign rx_valid = ~fifo_empty;
    assign pop      = rx_valid & rx_ready;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        rx_start_n = 1'b1;
        push       = 1'b0;
        set_ovr    = 1'b0;
        set_brk    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                rx_start_n = 1'b0;
                if (rx_done & ~rx_done_q) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push       = char_keep;
                set_brk    = break_error;
                set_ovr    = overflow_error | (push & fifo_full & ~pop);
                idle_cnt_d = '0;
                state_d    = break_error ? ST_RECOVER : ST_RUN;
            end
            ST_RECOVER: begin
                if (sample_tick) begin
                    if (!serial_data_in) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!cfg_enable) state_d = ST_IDLE;
        sts_overrun_d = (sts_overrun_q & ~sts_clr) | set_ovr;
        sts_break_d   = (sts_break_q & ~sts_clr) | set_brk;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            run_q         <= 1'b0;
            state_q       <= ST_IDLE;
            rx_done_q     <= 1'b0;
            idle_cnt_q    <= '0;
            sts_overrun_q <= 1'b0;
            sts_break_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            run_q         <= cfg_enable;
            state_q       <= state_d;
            rx_done_q     <= rx_done;
            idle_cnt_q    <= idle_cnt_d;
            sts_overrun_q <= sts_overrun_d;
            sts_break_q   <= sts_break_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_SIZE + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i ({cap_err, data_out}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {rx_err, rx_data} = fifo_rdata;
    assign sts_overrun       = sts_overrun_q;
    assign sts_break         = sts_break_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default depth 4, 8-bit characters).
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_enable;
    logic [15:0] cfg_baud_div;
    logic        sample_tick;
    logic        rx_start_n;
    logic        serial_data_in;
    logic        rx_done;
    logic [7:0]  data_out;
    logic        parity_error, stop_error, break_error, overflow_error;
    logic [7:0]  rx_data;
    logic [2:0]  rx_err;
    logic        rx_valid;
    logic        rx_ready;
    logic        sts_overrun, sts_break;
    logic        sts_clr;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic v1, v2, sn1;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_SIZE(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_baud_div(cfg_baud_div),
        .sample_tick(sample_tick), .rx_start_n(rx_start_n), .serial_data_in(serial_data_in),
        .rx_done(rx_done), .data_out(data_out), .parity_error(parity_error),
        .stop_error(stop_error), .break_error(break_error), .overflow_error(overflow_error),
        .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .sts_overrun(sts_overrun), .sts_break(sts_break), .sts_clr(sts_clr), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: raise rx_done with a character, hold it through CAPTURE, then drop it.
    task automatic send_char(input logic [7:0] d, input logic par, input logic stp,
                             input logic brk, input logic ovf, input logic clr_cap,
                             input logic pop_cap, output logic o_v1, output logic o_v2,
                             output logic o_sn1);
        data_out = d; parity_error = par; stop_error = stp;
        break_error = brk; overflow_error = ovf; rx_done = 1'b1;
        step();
        o_v1 = rx_valid; o_sn1 = rx_start_n;
        sts_clr = clr_cap; rx_ready = pop_cap;
        step();
        o_v2 = rx_valid;
        sts_clr = 1'b0; rx_ready = 1'b0; rx_done = 1'b0;
        parity_error = 1'b0; stop_error = 1'b0; break_error = 1'b0; overflow_error = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_enable = 1'b0; cfg_baud_div = 16'd0; serial_data_in = 1'b1;
        rx_done = 1'b0; data_out = 8'h00; parity_error = 1'b0; stop_error = 1'b0;
        break_error = 1'b0; overflow_error = 1'b0; rx_ready = 1'b0; sts_clr = 1'b0;
        step(); step();
        n_checks++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", sample_tick); end
        n_checks++; if (rx_start_n !== 1'b1) begin n_fail++; $display("FAIL reset_start_n: got %b expected 1", rx_start_n); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b expected 000", rx_err); end
        n_checks++; if (sts_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", sts_overrun); end
        n_checks++; if (sts_break !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b expected 0", sts_break); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_baud();
        logic exp;
        cfg_baud_div = 16'd3;
        cfg_enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = (k >= 3) && (((k - 3) % 4) == 0);
            n_checks++; if (sample_tick !== exp) begin n_fail++; $display("FAIL baud_tick k=%0d: got %b expected %b", k, sample_tick, exp); end
            if (k == 1) begin
                n_checks++; if ({busy, rx_start_n} !== 2'b10) begin n_fail++; $display("FAIL enable_busy_start: got %b expected 10", {busy, rx_start_n}); end
            end
        end
        cfg_enable = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_checks++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL baud_disabled k=%0d: got %b expected 0", k, sample_tick); end
        end
        n_checks++; if ({busy, rx_start_n} !== 2'b01) begin n_fail++; $display("FAIL disable_idle: got %b expected 01", {busy, rx_start_n}); end
    endtask

    task automatic test_single();
        cfg_baud_div = 16'd0;
        cfg_enable = 1'b1;
        step();
        n_checks++; if ({sample_tick, busy, rx_start_n} !== 3'b110) begin n_fail++; $display("FAIL div0_first_tick: got %b expected 110", {sample_tick, busy, rx_start_n}); end
        send_char(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1: got %b expected 0", v1); end
        n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL single_valid_n2: got %b expected 1", v2); end
        n_checks++; if (sn1 !== 1'b1) begin n_fail++; $display("FAIL capture_start_n: got %b expected 1", sn1); end
        n_checks++; if ({rx_err, rx_data} !== {3'b000, 8'h55}) begin n_fail++; $display("FAIL single_head: got %b_%h expected 000_55", rx_err, rx_data); end
        n_checks++; if (rx_start_n !== 1'b0) begin n_fail++; $display("FAIL rearm_run: got %b expected 0", rx_start_n); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b expected 0", rx_valid); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 4; i++) send_char(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        n_checks++; if (sts_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b expected 0", sts_overrun); end
        send_char(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        n_checks++; if (sts_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", sts_overrun); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if ({rx_valid, rx_data} !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL overrun_drain %0d: got %b/%h expected 1/%h", i, rx_valid, rx_data, 8'(i)); end
            rx_ready = 1'b1;
            step();
        end
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty: got %b expected 0", rx_valid); end
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        n_checks++; if (sts_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b expected 0", sts_overrun); end
    endtask

    task automatic test_break();
        serial_data_in = 1'b0;
        send_char(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        n_checks++; if (sts_break !== 1'b1) begin n_fail++; $display("FAIL break_sticky: got %b expected 1", sts_break); end
        n_checks++; if ({rx_err, rx_data} !== {3'b100, 8'h00}) begin n_fail++; $display("FAIL break_head: got %b_%h expected 100_00", rx_err, rx_data); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++; if (rx_start_n !== 1'b1) begin n_fail++; $display("FAIL recover_low_line: got %b expected 1", rx_start_n); end
        for (int i = 0; i <= 25; i++) begin
            serial_data_in = (i == 9) ? 1'b0 : 1'b1;
            step();
            n_checks++; if (rx_start_n !== ((i == 25) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL recover_count i=%0d: got %b expected %b", i, rx_start_n, (i == 25) ? 1'b0 : 1'b1); end
        end
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        n_checks++; if (sts_break !== 1'b0) begin n_fail++; $display("FAIL break_clr: got %b expected 0", sts_break); end
    endtask

    task automatic test_parity();
        logic [10:0] q[$];
`ifndef UART_RX_CTRL_ERR_DROP_EN
        q.push_back({3'b001, 8'hA3});
`endif
        q.push_back({3'b000, 8'h3C});
        send_char(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        send_char(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        for (int i = 0; i < q.size(); i++) begin
            n_checks++; if ({rx_valid, rx_err, rx_data} !== {1'b1, q[i]}) begin n_fail++; $display("FAIL parity_entry %0d: got %b_%b_%h expected 1_%b_%h", i, rx_valid, rx_err, rx_data, q[i][10:8], q[i][7:0]); end
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL parity_empty: got %b expected 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[4] = '{8'h12, 8'h13, 8'h14, 8'h16};
        send_char(8'h9C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v1, v2, sn1);
        n_checks++; if ({v2, rx_valid, rx_data} !== {1'b1, 1'b1, 8'h9C}) begin n_fail++; $display("FAIL empty_push_pop: got %b%b_%h expected 11_9c", v2, rx_valid, rx_data); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_char(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v1, v2, sn1);
        send_char(8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v1, v2, sn1);
        n_checks++; if (sts_overrun !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set: got %b expected 1", sts_overrun); end
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        send_char(8'h16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v1, v2, sn1);
        n_checks++; if (sts_overrun !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_overrun: got %b expected 0", sts_overrun); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({rx_valid, rx_data} !== {1'b1, exp_q[i]}) begin n_fail++; $display("FAIL full_push_pop_drain %0d: got %b/%h expected 1/%h", i, rx_valid, rx_data, exp_q[i]); end
            rx_ready = 1'b1;
            step();
        end
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_empty: got %b expected 0", rx_valid); end
        send_char(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v1, v2, sn1);
        n_checks++; if ({sts_overrun, rx_valid, rx_data} !== {1'b1, 1'b1, 8'h77}) begin n_fail++; $display("FAIL overflow_flag: got %b%b_%h expected 11_77", sts_overrun, rx_valid, rx_data); end
        rx_ready = 1'b1; sts_clr = 1'b1;
        step();
        rx_ready = 1'b0; sts_clr = 1'b0;
    endtask

    task automatic test_reset_mid_recover();
        serial_data_in = 1'b0;
        send_char(8'hE0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, v1, v2, sn1);
        step(); step();
        n_checks++; if ({busy, rx_valid, sts_break, sts_overrun, rx_start_n} !== 5'b11111) begin n_fail++; $display("FAIL pre_reset_state: got %b expected 11111", {busy, rx_valid, sts_break, sts_overrun, rx_start_n}); end
        rx_done = 1'b1; data_out = 8'hAA;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sample_tick, rx_start_n, rx_valid, rx_err, sts_overrun, sts_break, busy, rx_data} !== {1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got tick=%b start_n=%b valid=%b err=%b ovr=%b brk=%b busy=%b data=%h expected 0 1 0 000 0 0 0 00",
                     sample_tick, rx_start_n, rx_valid, rx_err, sts_overrun, sts_break, busy, rx_data);
        end
        step();
        cfg_enable = 1'b0; rx_done = 1'b0;
        reset_n = 1'b1;
        step(); step();
        n_checks++; if ({rx_valid, busy, rx_start_n} !== 3'b001) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 001", {rx_valid, busy, rx_start_n}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_baud();
        test_single();
        test_overrun();
        test_break();
        test_parity();
        test_back_to_back();
        test_reset_mid_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for `uart_receiver`:
- generates the 16x-baud sample enable;
- arms the receiver through `rx_start_n`;
- captures each completed character with its error flags into a small FIFO;
- presents bytes to the host over a valid/ready handshake;
- recovers from line breaks;
- keeps sticky status for software.

It sits between `uart_receiver` and the register/bus side of the UART. It runs in the same `clk` domain as the receiver, which is clock-enabled by `sample_tick`.

## Interface
- `DATA_SIZE`, 8, character width; must match `uart_receiver`
- `FIFO_DEPTH`, 4, receive FIFO entries, power of two ≥ 2
- `DIV_WIDTH`, 16, width of baud divisor
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `cfg_enable`  in  1  receive path enable
- `cfg_baud_div`  in  DIV_WIDTH  sample period minus one, in `clk` cycles
- `sample_tick`  out  1  one-cycle 16x-baud enable to receiver
- `rx_start_n`  out  1  receiver arm, active low
- `serial_data_in`  in  1  serial line (already synchronised), observed for break recovery
- `rx_done`  in  1  receiver character-complete level
- `data_out`  in  DATA_SIZE  receiver character
- `parity_error`, `stop_error`, `break_error`, `overflow_error`  in  1 each  receiver flags, valid with `rx_done`
- `rx_data`  out  DATA_SIZE  FIFO head data
- `rx_err`  out  3  FIFO head flags {break, stop, parity}
- `rx_valid`  out  1  FIFO non-empty
- `rx_ready`  in  1  host pop
- `sts_overrun`  out  1  sticky: FIFO-full drop or receiver `overflow_error`
- `sts_break`  out  1  sticky: break detected
- `sts_clr`  in  1  one-cycle pulse clearing both sticky bits
- `busy`  out  1  state ≠ IDLE

## Operation
Baud generator:
- Down-counter loads `cfg_baud_div` and pulses `sample_tick` when it reaches 0, then reloads. The tick period is `cfg_baud_div`+1 cycles; a divisor of 0 gives a tick every cycle.
- While `cfg_enable`=0 the counter is held at 0 and `sample_tick`=0.
- A divisor change takes effect at the next reload.

FSM states are IDLE, RUN, CAPTURE and RECOVER:
- IDLE: `rx_start_n`=1. Goes to RUN when `cfg_enable`=1.
- RUN: `rx_start_n`=0. A rising edge of `rx_done` (`rx_done` & ~`rx_done_q`) goes to CAPTURE.
- CAPTURE, one cycle:
  - `rx_start_n`=1 to rearm the receiver.
  - Push {flags, `data_out`}.
  - If `break_error`, set `sts_break` and go to RECOVER; otherwise go to RUN.
- RECOVER: `rx_start_n`=1. Counts consecutive `sample_tick`s with `serial_data_in`=1.
  - A low sample resets the count.
  - The 16th consecutive high goes to RUN.
- `cfg_enable`=0 in any state goes to IDLE next cycle. The FIFO contents are kept.

FIFO:
- Read/write pointers are log2(FIFO_DEPTH)+1 bits wide.
- Full when the pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- Pop happens when `rx_valid` & `rx_ready`.
- Push when full with no pop in the same cycle: the character is dropped, `sts_overrun` is set, and the FIFO is unchanged.
- Push and pop in the same cycle when full: both occur, no overrun.
- Push and pop when empty: the push occurs, `rx_valid` rises next cycle, and the pop is ignored.
- `rx_data`/`rx_err` show the head entry. They are don't-care when empty but must not be X after reset.

Sticky status:
- A set event in the same cycle as `sts_clr` wins: the bit stays 1.
- `overflow_error` sampled in CAPTURE also sets `sts_overrun`.

## Timing
- Reset values:
  - 0: `sample_tick`, `rx_valid`, `rx_data`, `rx_err`, `sts_overrun`, `sts_break`, `busy`, FIFO pointers.
  - `rx_start_n`=1, state IDLE.
- Edge of `rx_done` seen in cycle N → CAPTURE in N+1 → `rx_valid`=1 in N+2 (FIFO was empty).
- Pop in cycle N → next entry (or `rx_valid`=0) visible in N+1.
- `cfg_enable` rising in cycle N → `busy` and `rx_start_n`=0 in N+1. The first `sample_tick` occurs in cycle N+1 if the divisor is 0, otherwise `cfg_baud_div` cycles after N.
- `reset_n` asserted mid-frame: all state clears immediately (asynchronous). The partial character is never pushed.

## Configuration
- `UART_RX_CTRL_ERR_DROP_EN` defined: characters with parity or stop error are not pushed. Break characters are still pushed, and the RECOVER entry is unchanged.
- Undefined: every captured character is pushed with its flags.

## Structure
- `uart_pkg` holds:
  - the `rx_err_t` packed struct {break, stop, parity};
  - the FSM state enum;
  - the recovery constant `RX_IDLE_TICKS` = 16.
- Natural sub-module: `uart_rx_fifo` (parameterised synchronous FIFO with push/pop/full/empty). Baud generator and FSM stay in `uart_rx_ctrl`.

## Test plan
- Divisor 3, enable → `sample_tick` every 4 cycles; disable → tick stops next cycle and the counter reads 0.
- Receiver returns 0x55 with no errors → `rx_valid` two cycles after the `rx_done` edge, `rx_data`=0x55, `rx_err`=0; pop → `rx_valid`=0.
- 5 characters (0x01–0x05) with `rx_ready`=0, depth 4 → 0x01–0x04 stored, `sts_overrun`=1; pop all → 0x01..0x04 in order.
- `break_error` with 0x00 → `sts_break`=1, `rx_start_n` stays high until 16 consecutive high samples. A low sample at tick 10 restarts the count.
- `parity_error` on 0xA3 → stored with `rx_err`=001 without the macro; not stored with `UART_RX_CTRL_ERR_DROP_EN`.
- `sts_clr` coincident with an overrun drop → `sts_overrun` stays 1; `reset_n` pulse mid-RECOVER → every output back to its reset value.
